bch_ecc_header_checker: RTL and testbench

Receive-side counterpart of the HDMI data island header BCH encoder. Consumes the 32-bit packet header serially, one bit per pixel clock, LSbit first: 24 data bits, then 8 parity bits. Recomputes the BCH(32,24) parity, forms the syndrome and reports a clean, corrected or uncorrectable header to the packet parser. Sits between the TMDS channel-0 decode (bit 2 of the decoded TERC4 nibble) and the data island packet parser.

---
 rtl/bch_ecc_header_checker.sv | 158 +++++++++++++++
 tb/tb_bch_ecc_header_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bch_ecc_header_checker.sv
// Serial BCH(32,24) header checker: 24 data bits then 8 parity bits (LSbit first), 2-stage syndrome/classify pipeline.
// Optional single-error correction is enabled by defining BCH_ECC_CORRECTION_EN.
module bch_ecc_header_checker (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_bit_in,
    input  logic        i_bit_valid,
    input  logic        i_is_first_bit,
    output logic [23:0] o_header,
    output logic        o_header_valid,
    output logic [7:0]  o_syndrome,
    output logic        o_ecc_error,
    output logic        o_ecc_corrected
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} state_t;

    function automatic logic [7:0] f_step(input logic [7:0] ecc, input logic b);
        logic fb;
        fb = b ^ ecc[0];
        return (ecc >> 1) ^ (fb ? 8'h83 : 8'h00);
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic [7:0]  r_lfsr;
    logic [7:0]  r_par;
    logic [23:0] r_hdr;
    logic        r_s0_vld;
    logic        r_s1_vld;
    logic [23:0] r_s1_hdr;
    logic [7:0]  r_s1_syn;
    logic        w_restart;
    logic        w_take_data;
    logic        w_take_par;
    logic        w_last;
    logic [23:0] w_hdr_fix;
    logic        w_err;
    logic        w_cor;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_bit_valid && i_is_first_bit) begin
            w_state_nxt = S_DATA;
        end else if (i_bit_valid) begin
            case (r_state)
                S_DATA:   if (r_cnt == 5'd23) w_state_nxt = S_PARITY;
                S_PARITY: if (r_cnt == 5'd31) w_state_nxt = S_IDLE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_restart   = i_bit_valid & i_is_first_bit;
        w_take_data = i_bit_valid & ~w_restart & (r_state == S_DATA);
        w_take_par  = i_bit_valid & ~w_restart & (r_state == S_PARITY);
        w_last      = w_take_par & (r_cnt == 5'd31);
    end

    // Bit counter wraps to 0 after bit 31, matching its reset value.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt    <= 5'd0;
            r_lfsr   <= 8'h00;
            r_par    <= 8'h00;
            r_hdr    <= 24'h0;
            r_s0_vld <= 1'b0;
        end else begin
            r_s0_vld <= w_last;
            if (w_restart) begin
                r_cnt  <= 5'd1;
                r_lfsr <= f_step(8'h00, i_bit_in);
                r_hdr  <= {23'h0, i_bit_in};
            end else if (w_take_data) begin
                r_cnt        <= r_cnt + 5'd1;
                r_lfsr       <= f_step(r_lfsr, i_bit_in);
                r_hdr[r_cnt] <= i_bit_in;
            end else if (w_take_par) begin
                r_cnt             <= r_cnt + 5'd1;
                r_par[r_cnt[2:0]] <= i_bit_in;
            end
        end
    end

    // Stage 1 snapshots the finished packet so a back-to-back header can start immediately.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_s1_vld <= 1'b0;
            r_s1_hdr <= 24'h0;
            r_s1_syn <= 8'h00;
        end else begin
            r_s1_vld <= r_s0_vld;
            if (r_s0_vld) begin
                r_s1_hdr <= r_hdr;
                r_s1_syn <= r_lfsr ^ r_par;
            end
        end
    end

`ifdef BCH_ECC_CORRECTION_EN
    function automatic logic [7:0] f_data_syn(input int i);
        logic [7:0] ecc;
        ecc = 8'h00;
        for (int n = i; n < 24; n++) ecc = f_step(ecc, n == i);
        return ecc;
    endfunction

    logic [23:0] w_data_hit;
    logic [7:0]  w_par_hit;

    for (genvar g = 0; g < 24; g++) begin : g_data_syn
        localparam logic [7:0] SYN = f_data_syn(g);
        assign w_data_hit[g] = (r_s1_syn == SYN);
    end

    for (genvar k = 0; k < 8; k++) begin : g_par_syn
        assign w_par_hit[k] = (r_s1_syn == (8'h01 << k));
    end

    always_comb begin
        w_hdr_fix = r_s1_hdr ^ w_data_hit;
        w_cor     = |{w_data_hit, w_par_hit};
        w_err     = (r_s1_syn != 8'h00) & ~w_cor;
    end
`else
    always_comb begin
        w_hdr_fix = r_s1_hdr;
        w_cor     = 1'b0;
        w_err     = (r_s1_syn != 8'h00);
    end
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_header        <= 24'h0;
            o_header_valid  <= 1'b0;
            o_syndrome      <= 8'h00;
            o_ecc_error     <= 1'b0;
            o_ecc_corrected <= 1'b0;
        end else begin
            o_header_valid <= r_s1_vld;
            if (r_s1_vld) begin
                o_header        <= w_hdr_fix;
                o_syndrome      <= r_s1_syn;
                o_ecc_error     <= w_err;
                o_ecc_corrected <= w_cor;
            end
        end
    end

endmodule

// File: tb/tb_bch_ecc_header_checker.sv
// Directed bench for bch_ecc_header_checker: vector table plus back-to-back, abort, stall and reset sequences.
module tb_bch_ecc_header_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bit_in = 1'b0;
    logic        bit_vld = 1'b0;
    logic        first = 1'b0;
    logic [23:0] header;
    logic        hv;
    logic [7:0]  syndrome;
    logic        ecc_err;
    logic        ecc_cor;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int hv_q[$];

    bch_ecc_header_checker dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_bit_in       (bit_in),
        .i_bit_valid    (bit_vld),
        .i_is_first_bit (first),
        .o_header       (header),
        .o_header_valid (hv),
        .o_syndrome     (syndrome),
        .o_ecc_error    (ecc_err),
        .o_ecc_corrected(ecc_cor)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (hv) hv_q.push_back(cyc);
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    typedef struct {
        logic [23:0] hdr;
        logic [7:0]  par;
        logic [23:0] exp_hdr;
        logic [7:0]  exp_syn;
        logic        exp_err;
        logic        exp_cor;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_vld = 1'b0;
            first   = 1'b0;
        end
    endtask

    // Sends nbits of {par,hdr} LSbit first; stall_at inserts 5 invalid cycles before that bit.
    task automatic send_bits(input logic [23:0] hdr, input logic [7:0] par, input int nbits, input int stall_at);
        logic [31:0] word;
        word = {par, hdr};
        for (int i = 0; i < nbits; i++) begin
            if (i == stall_at) begin
                repeat (5) begin
                    @(negedge clk);
                    bit_vld = 1'b0;
                    first   = 1'b0;
                    bit_in  = 1'b1;
                end
            end
            @(negedge clk);
            bit_vld = 1'b1;
            first   = (i == 0);
            bit_in  = word[i];
        end
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bit_vld = 1'b0;
                first   = 1'b0;
            end
            if (hv) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_header"}, 32'(header), 32'h0);
        chk({tag, "_hv"}, 32'(hv), 32'h0);
        chk({tag, "_syndrome"}, 32'(syndrome), 32'h0);
        chk({tag, "_err"}, 32'(ecc_err), 32'h0);
        chk({tag, "_cor"}, 32'(ecc_cor), 32'h0);
    endtask

    initial begin
        int lat;
        int base;

`ifdef BCH_ECC_CORRECTION_EN
        vecs[0] = '{24'h000000, 8'h00, 24'h000000, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{24'h800000, 8'h83, 24'h800000, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{24'h000001, 8'h00, 24'h000000, 8'h4A, 1'b0, 1'b1};
        vecs[3] = '{24'h000000, 8'h03, 24'h000000, 8'h03, 1'b1, 1'b0};
        vecs[4] = '{24'h000000, 8'h01, 24'h000000, 8'h01, 1'b0, 1'b1};
        vecs[5] = '{24'h800000, 8'h00, 24'h000000, 8'h83, 1'b0, 1'b1};
        vecs[6] = '{24'hC00000, 8'h41, 24'hC00000, 8'h00, 1'b0, 1'b0};
`else
        vecs[0] = '{24'h000000, 8'h00, 24'h000000, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{24'h800000, 8'h83, 24'h800000, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{24'h000001, 8'h00, 24'h000001, 8'h4A, 1'b1, 1'b0};
        vecs[3] = '{24'h000000, 8'h03, 24'h000000, 8'h03, 1'b1, 1'b0};
        vecs[4] = '{24'h000000, 8'h01, 24'h000000, 8'h01, 1'b1, 1'b0};
        vecs[5] = '{24'h800000, 8'h00, 24'h800000, 8'h83, 1'b1, 1'b0};
        vecs[6] = '{24'hC00000, 8'h41, 24'hC00000, 8'h00, 1'b0, 1'b0};
`endif

        idle(3);
        chk_outputs_zero("reset");
        rst = 1'b0;
        idle(2);

        for (int v = 0; v < 7; v++) begin
            send_bits(vecs[v].hdr, vecs[v].par, 32, -1);
            wait_result(lat);
            chk($sformatf("v%0d_latency", v), 32'(lat), 32'd3);
            chk($sformatf("v%0d_header", v), 32'(header), 32'(vecs[v].exp_hdr));
            chk($sformatf("v%0d_syndrome", v), 32'(syndrome), 32'(vecs[v].exp_syn));
            chk($sformatf("v%0d_err", v), 32'(ecc_err), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_cor", v), 32'(ecc_cor), 32'(vecs[v].exp_cor));
            idle(1);
            chk($sformatf("v%0d_pulse_width", v), 32'(hv), 32'h0);
            chk($sformatf("v%0d_hold_header", v), 32'(header), 32'(vecs[v].exp_hdr));
            idle(2);
        end

        // Back-to-back clean headers with no gap
        hv_q.delete();
        send_bits(24'h800000, 8'h83, 32, -1);
        send_bits(24'h800000, 8'h83, 32, -1);
        idle(6);
        chk("b2b_pulse_count", 32'(hv_q.size()), 32'd2);
        if (hv_q.size() == 2) chk("b2b_spacing", 32'(hv_q[1] - hv_q[0]), 32'd32);
        chk("b2b_header", 32'(header), 32'h800000);
        chk("b2b_syndrome", 32'(syndrome), 32'h0);

        // Abort at bit 17, then a full clean header; stray valid bits in idle are ignored
        hv_q.delete();
        send_bits(24'hFFFFFF, 8'hFF, 17, -1);
        send_bits(24'hC00000, 8'h41, 32, -1);
        idle(6);
        chk("abort_pulse_count", 32'(hv_q.size()), 32'd1);
        chk("abort_header", 32'(header), 32'hC00000);
        chk("abort_syndrome", 32'(syndrome), 32'h0);
        chk("abort_err", 32'(ecc_err), 32'h0);
        hv_q.delete();
        repeat (4) begin
            @(negedge clk);
            bit_vld = 1'b1;
            first   = 1'b0;
            bit_in  = 1'b1;
        end
        idle(6);
        chk("idle_stray_bits", 32'(hv_q.size()), 32'd0);

        // Stall mid-DATA
        send_bits(24'h400000, 8'hC2, 32, 10);
        wait_result(lat);
        chk("stall_latency", 32'(lat), 32'd3);
        chk("stall_header", 32'(header), 32'h400000);
        chk("stall_syndrome", 32'(syndrome), 32'h0);
        chk("stall_err", 32'(ecc_err), 32'h0);
        idle(2);

        // Reset one cycle after bit 31 discards the in-flight result
        hv_q.delete();
        send_bits(24'h000001, 8'h00, 32, -1);
        @(negedge clk);
        bit_vld = 1'b0;
        first   = 1'b0;
        rst     = 1'b1;
        #1;
        chk_outputs_zero("in_reset");
        idle(2);
        chk_outputs_zero("in_reset2");
        rst = 1'b0;
        idle(6);
        chk("post_reset_no_pulse", 32'(hv_q.size()), 32'd0);
        chk_outputs_zero("post_reset");
        base = hv_q.size();
        send_bits(24'h800000, 8'h83, 32, -1);
        wait_result(lat);
        chk("recover_latency", 32'(lat), 32'd3);
        chk("recover_header", 32'(header), 32'h800000);
        chk("recover_syndrome", 32'(syndrome), 32'h0);
        idle(2);
        chk("recover_pulse_count", 32'(hv_q.size() - base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
